// File: rtl/pc_sel_ctrl.sv
// pc_sel_ctrl
//   Sequencing controller for the PC / memory-address selector. Each cycle
//   it decides how the PC moves (ALU load, +4, -4, hold) and where the memory
//   address comes from (PC or ALU). It also qualifies the word on the memory
//   bus as an instruction or as load data. In steady state the PC is one word
//   (4 bytes) ahead of the instruction on the bus.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   opcode       in   [6:0] opcode of the instruction on the memory bus
//   branch_taken in   branch comparator result for that instruction
//   stall_req    in   memory not ready; bus data invalid this cycle
//   pc_sel       out  [1:0] 00 ALU, 01 +4, 10 -4, 11 hold
//   mem_sel      out  0 = address from PC, 1 = address from ALU
//   instr_valid  out  bus word is an instruction to execute
//   load_valid   out  bus word is load data for writeback
//   trap         out  sticky illegal-opcode flag
//   retired_cnt  out  [REG_LEN-1:0] executed-instruction count (wraps)
module pc_sel_ctrl #(
  parameter int BOOT_CYCLES = 2,   // 1..15
  parameter int REG_LEN     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic               branch_taken,
  input  logic               stall_req,
  output logic [1:0]         pc_sel,
  output logic               mem_sel,
  output logic               instr_valid,
  output logic               load_valid,
  output logic               trap,
  output logic [REG_LEN-1:0] retired_cnt
);

  // State encoding
  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_STALL = 3'd4;
  localparam logic [2:0] S_TRAP  = 3'd5;

  // PC update selects
  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_DEC  = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

  // RV32I major opcodes
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  logic [2:0]         state, next_state;
  logic [3:0]         boot_cnt;
  logic               is_load, is_load_next;
  logic               trap_q, set_trap;
  logic [REG_LEN-1:0] cnt_q;
  logic               retire;

  // ---------------------------------------------------------------------------
  // Next-state and Mealy output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state   = state;
    pc_sel       = PC_HOLD;
    mem_sel      = 1'b0;
    instr_valid  = 1'b0;
    load_valid   = 1'b0;
    set_trap     = 1'b0;
    is_load_next = is_load;

    case (state)
      S_BOOT: begin
        // Last boot cycle starts the PC moving so it leads the first fetch.
        if (boot_cnt == BOOT_LAST) begin
          pc_sel     = PC_INC;
          next_state = S_RUN;
        end
      end

      S_RUN: begin
        if (stall_req) begin
          // PC already advanced past this word; step back so it is re-fetched.
          pc_sel     = PC_DEC;
          next_state = S_STALL;
        end else begin
          instr_valid = 1'b1;
          case (opcode)
            OP_JAL, OP_JALR: begin
              pc_sel     = PC_ALU;
              next_state = S_FLUSH;
            end
            OP_BRANCH: begin
              if (branch_taken) begin
                pc_sel     = PC_ALU;
                next_state = S_FLUSH;
              end else begin
                pc_sel = PC_INC;
              end
            end
            OP_LOAD, OP_STORE: begin
              // Hold the PC while the bus is borrowed for the data access.
              mem_sel      = 1'b1;
              pc_sel       = PC_HOLD;
              next_state   = S_MEM;
              is_load_next = (opcode == OP_LOAD);
            end
            OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_SYSTEM: begin
              pc_sel = PC_INC;
            end
            default: begin
              instr_valid = 1'b0;
              pc_sel      = PC_HOLD;
              set_trap    = 1'b1;
              next_state  = S_TRAP;
            end
          endcase
        end
      end

      S_MEM: begin
        if (!stall_req) begin
          load_valid = is_load;
          pc_sel     = PC_INC;
          next_state = S_RUN;
        end
      end

      S_FLUSH: begin
        // Bus holds the stale sequential fetch; drop it and restore the lead.
        pc_sel     = PC_INC;
        next_state = S_RUN;
      end

      S_STALL: begin
        if (!stall_req) begin
          pc_sel     = PC_INC;
          next_state = S_RUN;
        end
      end

      S_TRAP: begin
        next_state = S_TRAP;
      end

      default: begin
        // Unreachable encodings are treated as a fault.
        set_trap   = 1'b1;
        next_state = S_TRAP;
      end
    endcase
  end

  assign retire = (state == S_RUN) && instr_valid;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_BOOT;
      boot_cnt <= 4'd0;
      is_load  <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      state   <= next_state;
      is_load <= is_load_next;
      if (state == S_BOOT)
        boot_cnt <= boot_cnt + 4'd1;
      if (set_trap)
        trap_q <= 1'b1;
    end
  end

  // Retirement counter, wraps naturally at 2^REG_LEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (retire)
      cnt_q <= cnt_q + REG_LEN'(1);
  end

  assign trap        = trap_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sel_ctrl.sv
module tb_pc_sel_ctrl;

  localparam int BOOT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        stall_req;
  logic [1:0]  pc_sel;
  logic        mem_sel, instr_valid, load_valid, trap;
  logic [31:0] retired_cnt;

  pc_sel_ctrl #(.BOOT_CYCLES(BOOT), .REG_LEN(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .stall_req(stall_req), .pc_sel(pc_sel), .mem_sel(mem_sel),
    .instr_valid(instr_valid), .load_valid(load_valid), .trap(trap),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  pc;
    logic        ms, iv, lv, tr;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011,
                         LD = 7'b0000011, ST = 7'b0100011, OPR = 7'b0110011,
                         OPI = 7'b0010011, LUI = 7'b0110111, AUI = 7'b0010111,
                         SYS = 7'b1110011;
  logic [6:0] legal_tab [10] = '{JAL, JALR, BR, LD, ST, OPR, OPI, LUI, AUI, SYS};

  // ---------------- reference model (behavioural) ----------------
  int          boot_seen;
  bit          m_trapped, m_flush, m_mem, m_mem_load, m_stalled, m_trap_flag;
  logic [31:0] m_cnt;

  task automatic model_reset();
    boot_seen = 0; m_trapped = 0; m_flush = 0; m_mem = 0; m_mem_load = 0;
    m_stalled = 0; m_trap_flag = 0; m_cnt = '0;
  endtask

  task automatic model(input logic [6:0] op, input logic bt, input logic st,
                       output exp_t e);
    e = '0;
    e.pc  = 2'b11;
    e.tr  = m_trap_flag;
    e.cnt = m_cnt;
    if (m_trapped) begin
      // hold forever
    end else if (boot_seen < BOOT) begin
      if (boot_seen == BOOT - 1) e.pc = 2'b01;
      boot_seen++;
    end else if (m_mem) begin
      if (!st) begin e.pc = 2'b01; e.lv = m_mem_load; m_mem = 0; end
    end else if (m_flush) begin
      e.pc = 2'b01; m_flush = 0;
    end else if (m_stalled) begin
      if (!st) begin e.pc = 2'b01; m_stalled = 0; end
    end else if (st) begin
      e.pc = 2'b10; m_stalled = 1;
    end else begin
      case (op)
        JAL, JALR: begin e.iv = 1; e.pc = 2'b00; m_flush = 1; end
        BR:        begin e.iv = 1; e.pc = bt ? 2'b00 : 2'b01; m_flush = bt; end
        LD, ST:    begin e.iv = 1; e.ms = 1; m_mem = 1; m_mem_load = (op == LD); end
        OPR, OPI, LUI, AUI, SYS: begin e.iv = 1; e.pc = 2'b01; end
        default:   begin m_trapped = 1; m_trap_flag = 1; end
      endcase
    end
    if (e.iv) m_cnt = m_cnt + 32'd1;
  endtask

  // ---------------- driver (called at posedge+1) ----------------
  task automatic step(input logic [6:0] op, input logic bt, input logic st);
    exp_t e;
    opcode = op; branch_taken = bt; stall_req = st;
    model(op, bt, st, e);
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Reset asserted between edges; outputs must be at reset values before
  // the next edge (checked at the following negedge).
  task automatic mid_reset();
    exp_t e;
    opcode = 7'($urandom); branch_taken = 1'($urandom); stall_req = 1'($urandom);
    #1 rst = 1'b1;
    model_reset();
    e = '0; e.pc = 2'b11;
    q.push_back(e);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] o;
    if ($urandom_range(0, 99) < 3) o = 7'($urandom);
    else o = legal_tab[$urandom_range(0, 9)];
    return o;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        a = '{pc: pc_sel, ms: mem_sel, iv: instr_valid, lv: load_valid,
              tr: trap, cnt: retired_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got pc=%b ms=%b iv=%b lv=%b trap=%b cnt=%h exp pc=%b ms=%b iv=%b lv=%b trap=%b cnt=%h",
                   $time, a.pc, a.ms, a.iv, a.lv, a.tr, a.cnt,
                   e.pc, e.ms, e.iv, e.lv, e.tr, e.cnt);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    rst = 1'b1; opcode = '0; branch_taken = 0; stall_req = 0;
    model_reset();
    @(posedge clk); #1;
    e = '0; e.pc = 2'b11;
    q.push_back(e);                       // reset state
    @(posedge clk); #1;
    rst = 1'b0;

    // boot
    repeat (BOOT) step(OPI, 0, 0);
    // three OP-IMM
    repeat (3) step(OPI, 0, 0);
    // taken branch + flush, then not-taken branch
    step(BR, 1, 0); step(OPI, 0, 0);
    step(BR, 0, 0);
    // load then store
    step(LD, 0, 0); step(OPI, 0, 0);
    step(ST, 0, 0); step(OPI, 0, 0);
    // load with stall during the data cycle
    step(LD, 0, 0); step(OPI, 0, 1); step(OPI, 0, 0);
    // stalled JAL, then re-presented
    repeat (4) step(JAL, 1, 1);
    step(JAL, 0, 0);
    step(JAL, 0, 0); step(OPI, 0, 0);
    // non-branch opcode ignores branch_taken
    step(OPR, 1, 0);
    // counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    step(OPI, 0, 0);
    step(LUI, 0, 0);
    // illegal opcode, sticky trap
    step(7'b0000000, 0, 0);
    repeat (3) step(OPI, 1, 0);
    mid_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ((m_trapped && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
        mid_reset();
      else
        step(rand_op(), 1'($urandom), ($urandom_range(0, 99) < 15));
    end

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
